// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO that feeds uart_transmiter through its start/busy handshake,
// abandoning a launch if busy never rises within BUSY_TIMEOUT cycles.
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_wr_en,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                  o_overflow,
  output logic                  o_tx_start,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  input  logic                  i_tx_busy,
  output logic                  o_idle
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(BUSY_TIMEOUT);
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
  localparam logic [TW-1:0] ToLast  = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWaitHi, StWaitLo} state_e;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [TW-1:0]         r_to_cnt;
  state_e                r_state;

  state_e                w_state_next;
  logic [TW-1:0]         w_to_cnt_next;
  logic                  w_pop;
  logic                  w_wr_ok;

  assign o_full     = (r_count == FullCnt);
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_tx_data  = r_tx_data;
  assign o_idle     = (r_state == StIdle) && o_empty;
  assign w_wr_ok    = i_wr_en && !o_full;

  always_comb begin
    w_state_next  = r_state;
    w_to_cnt_next = r_to_cnt;
    w_pop         = 1'b0;
    o_tx_start    = 1'b0;
    case (r_state)
      StIdle: begin
        if (!o_empty && !i_tx_busy) begin
          w_pop         = 1'b1;
          w_to_cnt_next = '0;
          w_state_next  = StStart;
        end
      end
      StStart: begin
        o_tx_start   = 1'b1;
        w_state_next = StWaitHi;
      end
      StWaitHi: begin
        // A transmitter that never acknowledges loses the byte; no retry.
        if (i_tx_busy) begin
          w_state_next = StWaitLo;
        end else if (r_to_cnt == ToLast) begin
          w_state_next = StIdle;
        end else begin
          w_to_cnt_next = r_to_cnt + TW'(1);
        end
      end
      StWaitLo: begin
        if (!i_tx_busy) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_to_cnt   <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_to_cnt   <= w_to_cnt_next;
      r_overflow <= i_wr_en && o_full;
      if (w_wr_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        r_rptr    <= r_rptr + AW'(1);
        r_tx_data <= r_mem[r_rptr];
      end
      case ({w_wr_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; contents are dead once the pointers clear.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) r_mem[r_wptr] <= i_wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a behavioural transmitter model.
module tb_uart_tx_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned BT    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic          full, empty, overflow, tx_start, idle;
  logic [4:0]    count;
  logic [DW-1:0] tx_data;
  logic          tx_busy;
  logic          busy_m = 1'b0;
  logic          busy_force = 1'b0;
  logic          busy_never = 1'b0;
  int            busy_len = 10;

  int            n_checks = 0;
  int            n_fail = 0;
  int            n_pushed = 0;
  int            n_strobes = 0;
  int            cyc = 0;
  int            last_strobe_cyc = 0;
  int            prev_strobe_cyc = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] hold = '0;

  assign tx_busy = busy_m | busy_force;

  uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_wr_data (wr_data),
    .i_wr_en   (wr_en),
    .o_full    (full),
    .o_empty   (empty),
    .o_count   (count),
    .o_overflow(overflow),
    .o_tx_start(tx_start),
    .o_tx_data (tx_data),
    .i_tx_busy (tx_busy),
    .o_idle    (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Transmitter: busy rises the cycle after a strobe and stays high busy_len cycles.
  initial forever begin
    @(negedge clk);
    if (rst_n && tx_start && !busy_never) begin
      @(posedge clk);
      #1 busy_m = 1'b1;
      repeat (busy_len) @(posedge clk);
      #1 busy_m = 1'b0;
    end
  end

  // Monitor: every strobe pops the next expected byte; data must hold while busy.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      hold = '0;
    end else if (tx_start) begin
      n_strobes++;
      prev_strobe_cyc = last_strobe_cyc;
      last_strobe_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got tx_data 0x%0h, expected no strobe", tx_data);
      end else begin
        hold = exp_q.pop_front();
        chk("tx_data_order", 32'(tx_data), 32'(hold));
      end
    end else if (tx_busy) begin
      chk("tx_data_stable", 32'(tx_data), 32'(hold));
    end
  end

  task automatic push(input logic [DW-1:0] d, input bit acc);
    wr_en   = 1'b1;
    wr_data = d;
    if (acc) begin
      exp_q.push_back(d);
      n_pushed++;
    end
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (!(idle && !tx_busy) && k < budget) begin
      step(1);
      k++;
    end
    chk(name, 32'(idle && !tx_busy), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_full"},     32'(full),     32'd0);
    chk({tag, "_empty"},    32'(empty),    32'd1);
    chk({tag, "_count"},    32'(count),    32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_tx_data"},  32'(tx_data),  32'd0);
    chk({tag, "_idle"},     32'(idle),     32'd1);
  endtask

  initial begin
    int base;
    int k;
    int outstanding;

    // Reset state
    step(2);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step(2);

    // Single byte: strobe two cycles after the write
    push(8'hA5, 1'b1);
    chk("single_count_c1", 32'(count), 32'd1);
    chk("single_start_c1", 32'(tx_start), 32'd0);
    step(1);
    chk("single_start_c2", 32'(tx_start), 32'd1);
    chk("single_data_c2", 32'(tx_data), 32'hA5);
    wait_idle("single_idle", 40);

    // Fill and overflow with the transmitter held busy
    busy_force = 1'b1;
    step(1);
    for (int i = 0; i < DEPTH + 1; i++) begin
      push(8'(i), i < DEPTH);
      if (i == DEPTH - 2) chk("fill_not_full", 32'(full), 32'd0);
      if (i == DEPTH - 1) begin
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'(DEPTH));
      end
    end
    chk("overflow_pulse", 32'(overflow), 32'd1);
    step(1);
    chk("overflow_single", 32'(overflow), 32'd0);
    chk("overflow_count", 32'(count), 32'(DEPTH));
    base = n_strobes;
    busy_force = 1'b0;
    wait_idle("fill_drain_idle", 600);
    chk("fill_drain_strobes", 32'(n_strobes - base), 32'(DEPTH));
    chk("fill_drain_queue", 32'(exp_q.size()), 32'd0);

    // Simultaneous write and pop at count 3
    busy_force = 1'b1;
    step(1);
    for (int i = 0; i < 3; i++) push(8'($urandom), 1'b1);
    chk("simul_pre_count", 32'(count), 32'd3);
    busy_force = 1'b0;
    push(8'h5A, 1'b1);
    chk("simul_count", 32'(count), 32'd3);
    wait_idle("simul_idle", 200);
    chk("simul_queue", 32'(exp_q.size()), 32'd0);

    // Wrap-around: 40 random bytes in bursts of 5 while draining
    for (int b = 0; b < 8; b++) begin
      busy_len = int'($urandom_range(1, 4));
      k = 0;
      outstanding = n_pushed - n_strobes;
      while (outstanding > int'(DEPTH) - 5 && k < 500) begin
        step(1);
        k++;
        outstanding = n_pushed - n_strobes;
      end
      for (int i = 0; i < 5; i++) push(8'($urandom), 1'b1);
      step(int'($urandom_range(0, 12)));
    end
    wait_idle("wrap_idle", 800);
    chk("wrap_empty", 32'(empty), 32'd1);
    chk("wrap_queue", 32'(exp_q.size()), 32'd0);

    // Timeout: busy never rises, next byte strobed BT+2 cycles later
    busy_never = 1'b1;
    busy_len = 10;
    base = n_strobes;
    push(8'hC3, 1'b1);
    push(8'h3C, 1'b1);
    k = 0;
    while (n_strobes < base + 2 && k < 200) begin
      step(1);
      k++;
    end
    chk("timeout_strobes", 32'(n_strobes - base), 32'd2);
    chk("timeout_gap", 32'(last_strobe_cyc - prev_strobe_cyc), 32'(BT + 2));
    wait_idle("timeout_idle", BT + 20);
    busy_never = 1'b0;

    // Reset mid-transfer with 5 bytes queued
    busy_len = 20;
    for (int i = 0; i < 6; i++) push(8'($urandom), 1'b1);
    chk("rst_pre_count", 32'(count), 32'd5);
    step(5);
    chk("rst_pre_busy", 32'(tx_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_async");
    exp_q.delete();
    step(3);
    rst_n = 1'b1;
    base = n_strobes;
    step(40);
    chk("rst_no_strobe", 32'(n_strobes - base), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    push(8'h96, 1'b1);
    wait_idle("rst_new_idle", 80);
    chk("rst_new_strobe", 32'(n_strobes - base), 32'd1);
    chk("rst_new_queue", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
